sign_truncate: RTL and testbench
================================

SIGN_TRUNCATE -- requirements
Module: sign_truncate

Interface
REQ-001 Parameter CNT_W, default 8, width of the overflow counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer presents a word.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  signed 32-bit value to narrow.
REQ-007 in_mode  input  1  0 = IMM (18-bit field), 1 = MD (22-bit field); sampled with in_data.
REQ-008 out_valid  output  1  output entry available.
REQ-009 out_ready  input  1  consumer takes the output entry.
REQ-010 out_field  output  22  narrowed field; IMM result in [17:0], [21:18] = 0.
REQ-011 out_fits  output  1  1 = value was representable without saturation.
REQ-012 out_mode  output  1  in_mode of the word held in the output entry.
REQ-013 ovf_count  output  CNT_W  saturating count of accepted words with fits = 0.
REQ-014 clr_count  input  1  synchronous clear of ovf_count.

Function
REQ-015 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-016 Fit rule: IMM fits iff in_data[31:17] all equal; MD fits iff in_data[31:21] all equal.
REQ-017 Fitting value: IMM field = in_data[17:0]; MD field = in_data[21:0].
REQ-018 Non-fitting value saturates by in_data[31]: IMM 0 -> 18'h1FFFF, 1 -> 18'h20000; MD 0 -> 22'h1FFFFF, 1 -> 22'h200000.
REQ-019 Results held in a 2-entry in-order FIFO of {field, fits, mode}; out_* reflect the head entry.
REQ-020 Latency: word accepted at edge N is visible on out_* after edge N when the FIFO was empty (one cycle); never combinationally from in_* to out_*.
REQ-021 in_ready = (occupancy < 2) and not rst, driven from registered occupancy only (no dependence on out_ready).
REQ-022 out_valid = (occupancy > 0).
REQ-023 Occupancy: +1 on in-transfer only, -1 on out-transfer only, unchanged on both or neither.
REQ-024 Full (2 entries): in_ready = 0; in_valid ignored; contents and order preserved until popped.
REQ-025 Empty: out_valid = 0; out_ready ignored; occupancy never underflows.
REQ-026 out_* held stable while out_valid && !out_ready.
REQ-027 ovf_count increments by 1 on each in-transfer with fits = 0; holds at 2^CNT_W-1.
REQ-028 clr_count has priority: ovf_count = 0 at that edge; a coincident overflow increment is discarded.
REQ-029 in_mode is per-word; mixed IMM/MD streams are narrowed independently in order.

Reset
REQ-030 rst at any edge, including mid-stream with FIFO full: occupancy = 0, FIFO contents discarded, ovf_count = 0.
REQ-031 During and after reset: out_valid = 0, out_field = 0, out_fits = 0, out_mode = 0; in_ready = 0 while rst = 1, 1 on the first cycle after rst deasserts.
REQ-032 Transfers presented in a cycle with rst = 1 are dropped and not counted.

Verification
REQ-033 IMM in range: in_data = 32'hFFFF_FFFF, mode 0, out_ready = 1 -> next cycle out_field = 22'h03FFFF, out_fits = 1, ovf_count = 0.
REQ-034 IMM boundaries: 32'h0001_FFFF -> 18'h1FFFF fits = 1; 32'h0002_0000 -> 18'h1FFFF fits = 0; 32'hFFFE_0000 -> 18'h20000 fits = 1; 32'hFFFD_FFFF -> 18'h20000 fits = 0; ovf_count = 2.
REQ-035 MD boundaries: 32'h001F_FFFF -> 22'h1FFFFF fits = 1; 32'h8000_0000 -> 22'h200000 fits = 0.
REQ-036 Backpressure: out_ready = 0, push 3 words back-to-back -> in_ready drops after 2nd accept, 3rd held by producer; release out_ready -> three results in original order, none lost or duplicated.
REQ-037 Counter: CNT_W = 8, 300 non-fitting words -> ovf_count = 255; clr_count with coincident overflow -> 0 next cycle.
REQ-038 Reset mid-stream: FIFO full, assert rst one cycle -> out_valid = 0, ovf_count = 0, in_ready = 1 the cycle after release.

Source files
------------

// File: rtl/sign_truncate_if.sv
`default_nettype none
// ============================================================================
//  Module   : sign_truncate_if
//  Purpose  : Bundles the producer-side and consumer-side handshake and data
//             signals of the sign_truncate block.
//  Ports    : in_valid/in_ready/in_data/in_mode  - producer word channel
//             out_valid/out_ready/out_field/
//             out_fits/out_mode                  - consumer result channel
//             ovf_count/clr_count                - overflow statistics
//  Modports : master - environment side (drives inputs, observes outputs)
//             slave  - sign_truncate side
//  Revision : 1.0  initial release
// ============================================================================
interface sign_truncate_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [21:0]      out_field;
    logic             out_fits;
    logic             out_mode;
    logic [CNT_W-1:0] ovf_count;
    logic             clr_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready, clr_count,
        input  in_ready, out_valid, out_field, out_fits, out_mode, ovf_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, clr_count,
        output in_ready, out_valid, out_field, out_fits, out_mode, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/sign_truncate.sv
`default_nettype none
// ============================================================================
//  Module   : sign_truncate
//  Purpose  : Narrows signed 32-bit words to an 18-bit (IMM) or 22-bit (MD)
//             field with saturation, queues results in a 2-entry in-order
//             FIFO and counts words that required saturation.
//  Ports    : clk  - clock, all state on rising edge
//             rst  - synchronous active-high reset
//             bus  - sign_truncate_if.slave (word in, result out, counter)
//  Revision : 1.0  initial release
// ============================================================================
module sign_truncate #(
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sign_truncate_if.slave    bus
);
    localparam logic [1:0]       c_DEPTH   = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // FIFO storage and control
    logic [21:0]      r_field [0:1];
    logic             r_fits  [0:1];
    logic             r_mode  [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic [CNT_W-1:0] r_ovf_count;

    logic        w_imm_fits;
    logic        w_md_fits;
    logic        w_fits;
    logic [21:0] w_field;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_push;
    logic        w_pop;

    // A value fits when every bit above the field's sign bit copies it.
    assign w_imm_fits = (&bus.in_data[31:17]) | ~(|bus.in_data[31:17]);
    assign w_md_fits  = (&bus.in_data[31:21]) | ~(|bus.in_data[31:21]);
    assign w_fits     = bus.in_mode ? w_md_fits : w_imm_fits;

    always_comb begin
        w_field = 22'd0;
        if (bus.in_mode) begin
            if (w_md_fits)
                w_field = bus.in_data[21:0];
            else
                w_field = bus.in_data[31] ? 22'h200000 : 22'h1FFFFF;
        end else begin
            if (w_imm_fits)
                w_field = {4'd0, bus.in_data[17:0]};
            else
                w_field = bus.in_data[31] ? 22'h020000 : 22'h01FFFF;
        end
    end

    // in_ready depends only on registered occupancy (and rst), never on
    // out_ready, so a full FIFO refuses a word even while it is being drained.
    assign w_in_ready  = (r_occ < c_DEPTH) && !rst;
    assign w_out_valid = (r_occ != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= 2'd0;
            r_field[0] <= 22'd0;
            r_field[1] <= 22'd0;
            r_fits[0]  <= 1'b0;
            r_fits[1]  <= 1'b0;
            r_mode[0]  <= 1'b0;
            r_mode[1]  <= 1'b0;
        end else begin
            if (w_push) begin
                r_field[r_wr_ptr] <= w_field;
                r_fits[r_wr_ptr]  <= w_fits;
                r_mode[r_wr_ptr]  <= bus.in_mode;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Clear wins over a coincident increment; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_count)
            r_ovf_count <= '0;
        else if (w_push && !w_fits && (r_ovf_count != c_CNT_MAX))
            r_ovf_count <= r_ovf_count + 1'b1;
    end

    // Outputs are forced to zero when no entry is held so stale popped data
    // never shows on the result channel.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_field = w_out_valid ? r_field[r_rd_ptr] : 22'd0;
    assign bus.out_fits  = w_out_valid ? r_fits[r_rd_ptr]  : 1'b0;
    assign bus.out_mode  = w_out_valid ? r_mode[r_rd_ptr]  : 1'b0;
    assign bus.ovf_count = r_ovf_count;
endmodule
`default_nettype wire

// File: tb/tb_sign_truncate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sign_truncate
//  Purpose  : Directed self-checking bench for sign_truncate.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sign_truncate;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    sign_truncate_if #(.CNT_W(8)) bus ();

    sign_truncate #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one edge (caller guarantees in_ready).
    task automatic send(input logic [31:0] d, input logic m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h8000_0000;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        bus.clr_count = 1'b0;
        tick();
        tick();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_field !== 22'd0) $display("FAIL rst_out_field got %h exp 0", bus.out_field); else n_pass++;
        n_total++; if (bus.out_fits !== 1'b0 || bus.out_mode !== 1'b0) $display("FAIL rst_fits_mode got %b%b exp 00", bus.out_fits, bus.out_mode); else n_pass++;
        n_total++; if (bus.ovf_count !== 8'd0) $display("FAIL rst_ovf got %0d exp 0", bus.ovf_count); else n_pass++;
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", bus.in_ready); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.ovf_count !== 8'd0) $display("FAIL rst_dropped got v=%b ovf=%0d exp v=0 ovf=0", bus.out_valid, bus.ovf_count); else n_pass++;
    endtask

    task automatic test_imm_range();
        bus.out_ready = 1'b1;
        send(32'hFFFF_FFFF, 1'b0);
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL imm_range_valid got %b exp 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_field !== 22'h03FFFF || bus.out_fits !== 1'b1 || bus.out_mode !== 1'b0)
            $display("FAIL imm_range got %h/%b/%b exp 03ffff/1/0", bus.out_field, bus.out_fits, bus.out_mode); else n_pass++;
        n_total++; if (bus.ovf_count !== 8'd0) $display("FAIL imm_range_ovf got %0d exp 0", bus.ovf_count); else n_pass++;
    endtask

    task automatic test_imm_boundaries();
        logic [31:0] vin  [4] = '{32'h0001_FFFF, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFD_FFFF};
        logic [21:0] vexp [4] = '{22'h01FFFF,    22'h01FFFF,    22'h020000,    22'h020000};
        logic        fexp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(vin[i], 1'b0);
            n_total++; if (bus.out_field !== vexp[i] || bus.out_fits !== fexp[i] || bus.out_valid !== 1'b1)
                $display("FAIL imm_bound_%0d got %h/%b exp %h/%b", i, bus.out_field, bus.out_fits, vexp[i], fexp[i]); else n_pass++;
        end
        n_total++; if (bus.ovf_count !== 8'd2) $display("FAIL imm_bound_ovf got %0d exp 2", bus.ovf_count); else n_pass++;
    endtask

    task automatic test_md_mixed();
        logic [31:0] vin  [5] = '{32'h001F_FFFF, 32'h8000_0000, 32'hFFE0_0000, 32'h0020_0000, 32'h0020_0000};
        logic        vm   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [21:0] vexp [5] = '{22'h1FFFFF,    22'h200000,    22'h200000,    22'h1FFFFF,    22'h01FFFF};
        logic        fexp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send(vin[i], vm[i]);
            n_total++; if (bus.out_field !== vexp[i] || bus.out_fits !== fexp[i] || bus.out_mode !== vm[i])
                $display("FAIL md_mixed_%0d got %h/%b/%b exp %h/%b/%b", i, bus.out_field, bus.out_fits, bus.out_mode, vexp[i], fexp[i], vm[i]); else n_pass++;
        end
        n_total++; if (bus.ovf_count !== 8'd5) $display("FAIL md_mixed_ovf got %0d exp 5", bus.ovf_count); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.out_field !== 22'd0) $display("FAIL md_drain got v=%b f=%h exp v=0 f=0", bus.out_valid, bus.out_field); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0005;
        bus.in_mode   = 1'b0;
        tick();
        n_total++; if (bus.in_ready !== 1'b1 || bus.out_field !== 22'h000005) $display("FAIL bp_first got r=%b f=%h exp r=1 f=000005", bus.in_ready, bus.out_field); else n_pass++;
        bus.in_data = 32'hFFFF_FFFE;
        bus.in_mode = 1'b1;
        tick();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full_ready got %b exp 0", bus.in_ready); else n_pass++;
        bus.in_data = 32'h7FFF_FFFF;
        bus.in_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (bus.in_ready !== 1'b0 || bus.out_field !== 22'h000005 || bus.out_fits !== 1'b1 || bus.out_mode !== 1'b0)
                $display("FAIL bp_hold_%0d got r=%b f=%h/%b/%b exp r=0 f=000005/1/0", i, bus.in_ready, bus.out_field, bus.out_fits, bus.out_mode); else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_field !== 22'h3FFFFE || bus.out_fits !== 1'b1 || bus.out_mode !== 1'b1)
            $display("FAIL bp_second got v=%b f=%h/%b/%b exp v=1 f=3ffffe/1/1", bus.out_valid, bus.out_field, bus.out_fits, bus.out_mode); else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_field !== 22'h01FFFF || bus.out_fits !== 1'b0 || bus.out_mode !== 1'b0)
            $display("FAIL bp_third got v=%b f=%h/%b/%b exp v=1 f=01ffff/0/0", bus.out_valid, bus.out_field, bus.out_fits, bus.out_mode); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.ovf_count !== 8'd6) $display("FAIL bp_ovf got %0d exp 6", bus.ovf_count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send(32'h8000_0000, 1'b1);
        send(32'h4000_0000, 1'b0);
        n_total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) $display("FAIL mid_full got r=%b v=%b exp r=0 v=1", bus.in_ready, bus.out_valid); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b0 || bus.ovf_count !== 8'd0 || bus.out_field !== 22'd0 || bus.in_ready !== 1'b0)
            $display("FAIL mid_rst got v=%b ovf=%0d f=%h r=%b exp v=0 ovf=0 f=0 r=0", bus.out_valid, bus.ovf_count, bus.out_field, bus.in_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_release_ready got %b exp 1", bus.in_ready); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_after got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_counter();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h8000_0000;
        bus.in_mode   = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        n_total++; if (bus.ovf_count !== 8'd200) $display("FAIL cnt_200 got %0d exp 200", bus.ovf_count); else n_pass++;
        for (int i = 0; i < 100; i++) tick();
        n_total++; if (bus.ovf_count !== 8'd255) $display("FAIL cnt_sat got %0d exp 255", bus.ovf_count); else n_pass++;
        bus.clr_count = 1'b1;
        tick();
        n_total++; if (bus.ovf_count !== 8'd0) $display("FAIL cnt_clr got %0d exp 0", bus.ovf_count); else n_pass++;
        bus.clr_count = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_total++; if (bus.ovf_count !== 8'd1) $display("FAIL cnt_after_clr got %0d exp 1", bus.ovf_count); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL cnt_drain got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_imm_range();
        test_imm_boundaries();
        test_md_mixed();
        test_back_to_back();
        test_reset_midstream();
        test_counter();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
